mxint8_sum_seq: RTL and testbench
=================================

MXINT8_SUM_SEQ -- requirements
Module: mxint8_sum_seq

Interface
REQ-001 Parameter BLOCK_SIZE, default 32; elements per MX block.
REQ-002 Parameter SCALE_WIDTH, default 8; shared E8M0 scale width.
REQ-003 Parameter MXINT8_ELEMENT_WIDTH, default 8; two's-complement element, value = int/64.
REQ-004 Parameter FLOAT32_WIDTH, default 32; IEEE-754 binary32 result.
REQ-005 One clock and one reset: i_clk input, 1 bit, rising-edge clock.
REQ-006 i_rst input, 1 bit; reset is asynchronous and active-high.
REQ-007 i_in_valid  input  1  element beat valid.
REQ-008 o_in_ready  output  1  block accepts beat.
REQ-009 i_element  input  MXINT8_ELEMENT_WIDTH  signed element.
REQ-010 i_scale  input  SCALE_WIDTH  block scale, sampled only on first beat.
REQ-011 i_in_last  input  1  marks final beat of block.
REQ-012 o_out_valid  output  1  result valid.
REQ-013 i_out_ready  input  1  consumer accepts result.
REQ-014 o_float32  output  FLOAT32_WIDTH  block sum.
REQ-015 o_protocol_err  output  1  sticky; i_in_last mismatched with beat count.

Function
REQ-016 FSM states IDLE, ACCUM, NORM, OUT; beat = i_in_valid && o_in_ready on rising i_clk.
REQ-017 o_in_ready = 1 in IDLE and ACCUM only; 0 in NORM and OUT.
REQ-018 IDLE: beat clears-and-loads accumulator with sign-extended i_element, latches i_scale, count=1, goes to ACCUM (BLOCK_SIZE=1: goes to NORM).
REQ-019 ACCUM: each beat adds sign-extended i_element; count increments; beat with count==BLOCK_SIZE-1 goes to NORM.
REQ-020 Accumulator is signed, MXINT8_ELEMENT_WIDTH+clog2(BLOCK_SIZE) bits (13 at defaults); never overflows.
REQ-021 i_in_last high on non-final beat or low on final beat sets o_protocol_err; block still completes by count only.
REQ-022 NORM (one cycle): M=|acc|, p=leading-one index of M; biased exponent E = scale - 6 + p (signed, wide enough for no wrap); mantissa = M bits below leading one, left-aligned in 23 bits, low bits zero (exact).
REQ-023 Special cases, priority order: scale==all-ones -> 0x7FC00000; acc==0 -> 0x00000000; E<=0 -> signed zero; E>=255 -> signed infinity.
REQ-024 Sign bit = sign of acc.
REQ-025 OUT: o_out_valid=1, o_float32 stable until i_out_ready; on handshake return to IDLE.
REQ-026 Latency: o_out_valid rises 2 cycles after final-beat edge (NORM, then OUT); back-to-back blocks: throughput BLOCK_SIZE+2 cycles.
REQ-027 i_in_valid ignored while o_in_ready=0; i_scale ignored on non-first beats.

Reset
REQ-028 While i_rst high: state IDLE, count 0, accumulator 0, o_out_valid 0, o_float32 0, o_protocol_err 0, o_in_ready 1.
REQ-029 Reset mid-block or mid-OUT discards partial/pending result; no output for that block.
REQ-030 o_protocol_err clears only by reset.

Structure
REQ-031 SCALE_WIDTH, element/float widths, FLOAT32 sign/exponent/mantissa field positions and NaN/infinity constants live in the shared includes (scalar_includes, mxint8_includes).
REQ-032 Combinational normalize/pack logic is sub-module mxint8_acc_to_fp32 (acc, scale -> float32); FSM, counter, registers stay in mxint8_sum_seq.

Verification
REQ-033 32 beats of +1, scale 127 -> o_float32 0x3F000000 two cycles after final beat.
REQ-034 32 beats of -128 (0x80), scale 127 -> 0xC2800000; o_protocol_err 0.
REQ-035 Alternating +5/-5, scale 130 -> 0x00000000; scale 0xFF with any data -> 0x7FC00000; scale 0 with one +1, rest 0 -> 0x00000000 (flush).
REQ-036 i_out_ready held low 5 cycles in OUT -> o_float32/o_out_valid stable, o_in_ready 0, offered beats ignored; next block then accepted correctly.
REQ-037 i_in_last on beat 10 -> o_protocol_err 1 and stays 1; result still from 32 beats.
REQ-038 i_rst pulsed after 17 beats -> all outputs reset values; following clean block of +1, scale 127 -> 0x3F000000.

Source files
------------

// File: rtl/mxint8_sum_seq_pkg.sv
// Shared constants for the MXINT8 block-sum datapath.
// Holds the MX element/scale formats, the IEEE-754 binary32 field layout and
// special encodings, and the sequencer state type.
package mxint8_sum_seq_pkg;

    // MX block format
    localparam int MX_BLOCK_SIZE     = 32;
    localparam int MX_SCALE_WIDTH    = 8;  // E8M0 shared exponent
    localparam int MX_ELEM_WIDTH     = 8;  // two's-complement element
    localparam int MX_ELEM_FRAC_BITS = 6;  // element value = int / 2**6

    // IEEE-754 binary32 layout
    localparam int FP32_WIDTH      = 32;
    localparam int FP32_SIGN_BIT   = 31;
    localparam int FP32_EXP_WIDTH  = 8;
    localparam int FP32_MANT_WIDTH = 23;
    localparam int FP32_EXP_MAX    = 255;
    localparam logic [FP32_WIDTH-1:0] FP32_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_NORM  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/mxint8_sum_seq_acc.sv
// mxint8_acc_to_fp32: combinational normalize/pack of a signed integer block
// sum into IEEE-754 binary32.
//   i_acc     : signed accumulator (element units, 6 fractional bits)
//   i_scale   : E8M0 block scale (all-ones encodes NaN)
//   o_float32 : packed binary32 result
// Results whose biased exponent would be <= 0 flush to signed zero; results
// whose biased exponent reaches 255 saturate to signed infinity. The mantissa
// is exact because the accumulator is never wider than 24 bits.
module mxint8_acc_to_fp32
    import mxint8_sum_seq_pkg::*;
#(
    parameter int ACC_WIDTH   = 13,
    parameter int SCALE_WIDTH = MX_SCALE_WIDTH
) (
    input  logic [ACC_WIDTH-1:0]   i_acc,
    input  logic [SCALE_WIDTH-1:0] i_scale,
    output logic [FP32_WIDTH-1:0]  o_float32
);

    localparam int IDX_WIDTH      = $clog2(ACC_WIDTH);
    // Wide enough that scale + index - 6 never wraps.
    localparam int EXP_CALC_WIDTH = SCALE_WIDTH + IDX_WIDTH + 2;
    localparam int SHIFT_WIDTH    = ACC_WIDTH + FP32_MANT_WIDTH;

    logic                             sign;
    logic [ACC_WIDTH-1:0]             mag;
    logic [IDX_WIDTH-1:0]             lead_idx;
    logic signed [EXP_CALC_WIDTH-1:0] exp_biased;
    logic [SHIFT_WIDTH-1:0]           aligned;
    logic [FP32_MANT_WIDTH-1:0]       mant;

    always_comb begin
        sign = i_acc[ACC_WIDTH-1];
        // The most negative sum wraps to itself, which read unsigned is the
        // correct magnitude.
        mag  = sign ? (~i_acc + 1'b1) : i_acc;

        lead_idx = '0;
        for (int i = 0; i < ACC_WIDTH; i++) begin
            if (mag[i]) lead_idx = IDX_WIDTH'(i);
        end

        // value = mag * 2**(scale - 127 - 6), leading one at bit lead_idx
        exp_biased = $signed({{(EXP_CALC_WIDTH-SCALE_WIDTH){1'b0}}, i_scale})
                   + $signed({{(EXP_CALC_WIDTH-IDX_WIDTH){1'b0}}, lead_idx})
                   - EXP_CALC_WIDTH'(MX_ELEM_FRAC_BITS);

        // Shift the leading one to bit 23; bits below it are the fraction.
        aligned = {mag, {FP32_MANT_WIDTH{1'b0}}} >> lead_idx;
        mant    = aligned[FP32_MANT_WIDTH-1:0];

        if (&i_scale) begin
            o_float32 = FP32_QNAN;
        end else if (i_acc == '0) begin
            o_float32 = '0;
        end else if (exp_biased <= EXP_CALC_WIDTH'(0)) begin
            o_float32 = {sign, {(FP32_WIDTH-1){1'b0}}};
        end else if (exp_biased >= EXP_CALC_WIDTH'(FP32_EXP_MAX)) begin
            o_float32 = {sign, {FP32_EXP_WIDTH{1'b1}}, {FP32_MANT_WIDTH{1'b0}}};
        end else begin
            o_float32 = {sign, exp_biased[FP32_EXP_WIDTH-1:0], mant};
        end
    end

endmodule

// File: rtl/mxint8_sum_seq.sv
// mxint8_sum_seq: sums one MXINT8 block (BLOCK_SIZE elements sharing one E8M0
// scale) and emits the total as IEEE-754 binary32.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_in_valid/o_in_ready, i_element, i_scale, i_in_last : element beats
//   o_out_valid/i_out_ready, o_float32                   : block result
//   o_protocol_err      : sticky, i_in_last disagreed with the beat count
//   o_dbg_state         : current sequencer state (state_t encoding)
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high; the producer holds its payload stable while valid is high
// and ready is low. Ready is never combinationally dependent on valid.
module mxint8_sum_seq
    import mxint8_sum_seq_pkg::*;
#(
    parameter int BLOCK_SIZE           = MX_BLOCK_SIZE,
    parameter int SCALE_WIDTH          = MX_SCALE_WIDTH,
    parameter int MXINT8_ELEMENT_WIDTH = MX_ELEM_WIDTH,
    parameter int FLOAT32_WIDTH        = FP32_WIDTH
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_in_valid,
    output logic                            o_in_ready,
    input  logic [MXINT8_ELEMENT_WIDTH-1:0] i_element,
    input  logic [SCALE_WIDTH-1:0]          i_scale,
    input  logic                            i_in_last,
    output logic                            o_out_valid,
    input  logic                            i_out_ready,
    output logic [FLOAT32_WIDTH-1:0]        o_float32,
    output logic                            o_protocol_err,
    output logic [1:0]                      o_dbg_state
);

    localparam int ACC_WIDTH = MXINT8_ELEMENT_WIDTH + $clog2(BLOCK_SIZE);
    localparam int CNT_WIDTH = $clog2(BLOCK_SIZE + 1);
    localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(BLOCK_SIZE - 1);

    state_t                     state_q, state_d;
    logic [CNT_WIDTH-1:0]       count_q, count_d;
    logic [ACC_WIDTH-1:0]       acc_q, acc_d;
    logic [SCALE_WIDTH-1:0]     scale_q, scale_d;
    logic [FLOAT32_WIDTH-1:0]   result_q, result_d;
    logic                       err_q, err_d;

    logic                       beat;
    logic                       final_beat;
    logic [ACC_WIDTH-1:0]       elem_ext;
    logic [FP32_WIDTH-1:0]      packed_fp;

    mxint8_acc_to_fp32 #(
        .ACC_WIDTH   (ACC_WIDTH),
        .SCALE_WIDTH (SCALE_WIDTH)
    ) u_acc_to_fp32 (
        .i_acc     (acc_q),
        .i_scale   (scale_q),
        .o_float32 (packed_fp)
    );

    assign o_in_ready     = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
    assign o_out_valid    = (state_q == ST_OUT);
    assign o_float32      = result_q;
    assign o_protocol_err = err_q;
    assign o_dbg_state    = state_q;

    assign beat     = i_in_valid && o_in_ready;
    assign elem_ext = ACC_WIDTH'($signed(i_element));

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        scale_d    = scale_q;
        result_d   = result_q;
        err_d      = err_q;
        final_beat = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (beat) begin
                    acc_d      = elem_ext;
                    scale_d    = i_scale;
                    count_d    = CNT_WIDTH'(1);
                    final_beat = (BLOCK_SIZE == 1);
                    state_d    = final_beat ? ST_NORM : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (beat) begin
                    acc_d      = acc_q + elem_ext;
                    count_d    = count_q + CNT_WIDTH'(1);
                    final_beat = (count_q == LAST_COUNT);
                    if (final_beat) state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                result_d = FLOAT32_WIDTH'(packed_fp);
                state_d  = ST_OUT;
            end
            ST_OUT: begin
                if (i_out_ready) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Block length is set by the count; i_in_last is only cross-checked.
        if (beat && (i_in_last != final_beat)) err_d = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            scale_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            scale_q  <= scale_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_mxint8_sum_seq.sv
module tb_mxint8_sum_seq;
    import mxint8_sum_seq_pkg::*;

    localparam int BS = 32;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [7:0]  i_element;
    logic [7:0]  i_scale;
    logic        i_in_last;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [31:0] o_float32;
    logic        o_protocol_err;
    logic [1:0]  o_dbg_state;

    always #5 clk = ~clk;

    mxint8_sum_seq dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_in_valid     (i_in_valid),
        .o_in_ready     (o_in_ready),
        .i_element      (i_element),
        .i_scale        (i_scale),
        .i_in_last      (i_in_last),
        .o_out_valid    (o_out_valid),
        .i_out_ready    (i_out_ready),
        .o_float32      (o_float32),
        .o_protocol_err (o_protocol_err),
        .o_dbg_state    (o_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic        exp_err;
    logic [7:0]  blk[BS];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: real value sum/64 * 2**(scale-127) built in double precision,
    // then re-packed as binary32 with flush-to-zero and saturate-to-infinity.
    function automatic logic [31:0] model_fp32(input int s, input int sc);
        real         v;
        logic [63:0] b;
        int          e;
        if (sc == 255) return 32'h7FC0_0000;
        if (s == 0)    return 32'h0000_0000;
        v = real'(s) * (2.0 ** (sc - 133));
        b = $realtobits(v);
        e = int'(b[62:52]) - 1023 + 127;
        if (e <= 0)   return {b[63], 31'b0};
        if (e >= 255) return {b[63], 8'hFF, 23'b0};
        return {b[63], e[7:0], b[51:29]};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_in_ready"},  32'(o_in_ready),     32'd1);
        check_val({tag, "_out_valid"}, 32'(o_out_valid),    32'd0);
        check_val({tag, "_float32"},   o_float32,           32'd0);
        check_val({tag, "_perr"},      32'(o_protocol_err), 32'd0);
        check_val({tag, "_state"},     32'(o_dbg_state),    32'(ST_IDLE));
    endtask

    // ---------------- driver ----------------
    // Sends blk[] with the given scale; i_in_last is raised on beat last_at.
    // hold: cycles i_out_ready stays low in OUT while junk beats are offered.
    // rst_after >= 0: reset is pulsed after that many beats, no result expected.
    task automatic send_block(input int sc, input int last_at, input int hold,
                              input int max_gap, input int rst_after);
        int          s;
        logic [31:0] exp_v;
        s = 0;
        for (int i = 0; i < BS; i++) s += int'($signed(blk[i]));
        if (rst_after < 0) begin
            exp_q.push_back(model_fp32(s, sc));
            if (last_at != BS - 1) exp_err = 1'b1;
        end
        for (int i = 0; i < BS; i++) begin
            if (i == rst_after) begin
                @(negedge clk);
                i_in_valid = 1'b0;
                rst        = 1'b1;
                exp_err    = 1'b0;
                #1;
                check_reset_outputs("midblk_rst");
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            repeat ($urandom_range(0, max_gap)) begin
                @(negedge clk);
                i_in_valid = 1'b0;
                i_element  = 8'($urandom);
                i_scale    = 8'($urandom);
                i_in_last  = 1'($urandom);
            end
            @(negedge clk);
            check_val("in_ready_accept", 32'(o_in_ready), 32'd1);
            i_in_valid = 1'b1;
            i_element  = blk[i];
            i_scale    = (i == 0) ? 8'(sc) : 8'($urandom);
            i_in_last  = (i == last_at);
        end
        @(negedge clk);
        i_in_valid = 1'b0;
        i_in_last  = 1'b0;
        check_val("norm_out_valid", 32'(o_out_valid), 32'd0);
        check_val("norm_in_ready",  32'(o_in_ready),  32'd0);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        check_val("out_valid",    32'(o_out_valid),    32'd1);
        check_val("result",       o_float32,           exp_v);
        check_val("protocol_err", 32'(o_protocol_err), 32'(exp_err));
        repeat (hold) begin
            i_in_valid = 1'b1;
            i_element  = 8'($urandom);
            i_scale    = 8'($urandom);
            i_in_last  = 1'($urandom);
            @(negedge clk);
            check_val("hold_valid",    32'(o_out_valid), 32'd1);
            check_val("hold_result",   o_float32,        exp_v);
            check_val("hold_in_ready", 32'(o_in_ready),  32'd0);
        end
        i_in_valid  = 1'b0;
        i_in_last   = 1'b0;
        i_out_ready = 1'b1;
        @(negedge clk);
        i_out_ready = 1'b0;
        check_val("post_hs_valid", 32'(o_out_valid), 32'd0);
        check_val("post_hs_ready", 32'(o_in_ready),  32'd1);
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int i = 0; i < BS; i++) blk[i] = v;
    endtask

    task automatic fill_random();
        for (int i = 0; i < BS; i++) blk[i] = 8'($urandom);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst         = 1'b1;
        i_in_valid  = 1'b0;
        i_element   = '0;
        i_scale     = '0;
        i_in_last   = 1'b0;
        i_out_ready = 1'b0;
        exp_err     = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        fill_const(8'd1);
        send_block(127, BS - 1, 0, 0, -1);          // 0x3F000000
        fill_const(8'h80);
        send_block(127, BS - 1, 0, 0, -1);          // 0xC2800000
        for (int i = 0; i < BS; i++) blk[i] = (i % 2 == 0) ? 8'd5 : 8'hFB;
        send_block(130, BS - 1, 0, 1, -1);          // zero sum
        fill_random();
        send_block(255, BS - 1, 0, 1, -1);          // NaN
        fill_const(8'd0);
        blk[0] = 8'd1;
        send_block(0, BS - 1, 0, 0, -1);            // flushed to zero
        fill_const(8'd127);
        send_block(254, BS - 1, 0, 0, -1);          // +infinity
        fill_const(8'h80);
        send_block(250, BS - 1, 0, 0, -1);          // -infinity
        fill_const(8'd1);
        send_block(127, BS - 1, 5, 0, -1);          // stalled consumer

        for (int n = 0; n < 20; n++) begin
            int sc;
            fill_random();
            sc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(110, 150));
            send_block(sc, BS - 1, int'($urandom_range(0, 3)), 2, -1);
        end

        fill_random();
        send_block(127, 10, 0, 0, -1);              // early last -> sticky err
        fill_random();
        send_block(131, BS - 1, 1, 1, -1);          // err stays set

        fill_const(8'd1);
        send_block(127, BS - 1, 0, 0, 17);          // reset after 17 beats
        fill_const(8'd1);
        send_block(127, BS - 1, 0, 0, -1);          // clean block after reset

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected test completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
